// File: rtl/packet_grant_mux.sv
// Locks onto the source picked by the arbiter's one-hot grant and forwards that
// source's packet through a single registered output stage, then signals fin/ready.
module packet_grant_mux #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   grant_i,
  output logic           ready_o,
  output logic [N-1:0]   fin_o,
  input  logic [N*W-1:0] s_tdata_i,
  input  logic [N-1:0]   s_tvalid_i,
  input  logic [N-1:0]   s_tlast_i,
  output logic [N-1:0]   s_tready_o,
  output logic [W-1:0]   m_tdata_o,
  output logic           m_tvalid_o,
  output logic           m_tlast_o,
  input  logic           m_tready_i,
  output logic           grant_err_o,
  output logic           len_err_o
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN, DONE} state_e;

  state_e        state_q;
  logic [SW-1:0] sel_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  m_tdata_q;
  logic          m_tvalid_q, m_tlast_q;
  logic          grant_err_q, len_err_q;

  logic [SW-1:0] low_idx;
  logic          grant_onehot, out_free, sel_tvalid, sel_tlast, xfer, at_max;
  logic [W-1:0]  sel_tdata;

  // Lowest set bit wins, so a malformed grant still serves a well-defined source.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (grant_i[i]) low_idx = SW'(i);
  end

  assign grant_onehot = (grant_i & (grant_i - N'(1))) == '0;
  assign out_free     = !m_tvalid_q || m_tready_i;
  assign sel_tdata    = s_tdata_i[sel_q*W +: W];
  assign sel_tvalid   = s_tvalid_i[sel_q];
  assign sel_tlast    = s_tlast_i[sel_q];
  assign xfer         = (state_q == LOCK) && sel_tvalid && out_free;
  assign at_max       = cnt_q == CW'(MAX_BEATS - 1);

  always_comb begin
    s_tready_o = '0;
    if (state_q == LOCK) s_tready_o[sel_q] = out_free;
  end

  always_comb begin
    fin_o = '0;
    if (state_q == DONE) fin_o[sel_q] = 1'b1;
  end

  assign ready_o     = state_q == IDLE;
  assign m_tdata_o   = m_tdata_q;
  assign m_tvalid_o  = m_tvalid_q;
  assign m_tlast_o   = m_tlast_q;
  assign grant_err_o = grant_err_q;
  assign len_err_o   = len_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      grant_err_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      grant_err_q <= 1'b0;
      len_err_q   <= 1'b0;
      case (state_q)
        IDLE: if (grant_i != '0) begin
          sel_q       <= low_idx;
          grant_err_q <= !grant_onehot;
          state_q     <= LOCK;
        end
        LOCK: begin
          if (xfer) begin
            m_tdata_q  <= sel_tdata;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= sel_tlast || at_max;
            cnt_q      <= cnt_q + CW'(1);
            // Truncation closes the packet here; leftover source beats stay queued.
            if (sel_tlast || at_max) state_q <= DRAIN;
            if (!sel_tlast && at_max) len_err_q <= 1'b1;
          end else if (m_tready_i) begin
            m_tvalid_q <= 1'b0;
          end
        end
        DRAIN: if (m_tvalid_q && m_tready_i && m_tlast_q) begin
          m_tvalid_q <= 1'b0;
          state_q    <= DONE;
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_packet_grant_mux.sv
// Bench for packet_grant_mux: directed vectors, hand sequences and a randomized
// multi-source run scored against a packet-level model with an in-bench arbiter.
module tb_packet_grant_mux;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAXB = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   grant = '0;
  logic           ready;
  logic [N-1:0]   fin;
  logic [N*W-1:0] s_tdata = '0;
  logic [N-1:0]   s_tvalid = '0, s_tlast = '0, s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid, m_tlast;
  logic           m_tready = 1'b0;
  logic           grant_err, len_err;

  packet_grant_mux #(.N(N), .W(W), .MAX_BEATS(MAXB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .grant_i(grant), .ready_o(ready), .fin_o(fin),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
    .grant_err_o(grant_err), .len_err_o(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    int           nbeats;
    bit           last;
    int           rdy_mode;
    logic [7:0]   pat;
    logic [N-1:0] exp_fin;
    int           exp_beats;
    int           exp_lerr;
    int           exp_gerr;
  } vec_t;

  logic [W-1:0] src_d [N][$];
  bit           src_l [N][$];
  int           drv_ptr [N];
  int           mdl_ptr [N];
  int           fin_cnt [N];
  int           pk_issued [N];
  logic [W:0]   exp_q [$];
  int           fin_log [$];

  int n_cmp = 0, n_err = 0;
  int beats_out, lerr_cnt, gerr_cnt, exp_lerr, rr, pat_idx, rdy_mode;
  bit auto_arb, gap_en, fin_seen, hold_v;
  logic [W:0]   hold_val;
  logic [N-1:0] served, fin_acc;
  logic [7:0]   rdy_pat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) begin
      src_d[i].delete(); src_l[i].delete();
      drv_ptr[i] = 0; mdl_ptr[i] = 0; fin_cnt[i] = 0; pk_issued[i] = 0;
    end
    exp_q.delete(); fin_log.delete();
    beats_out = 0; lerr_cnt = 0; gerr_cnt = 0; exp_lerr = 0;
    fin_acc = '0; fin_seen = 0; hold_v = 0; served = '0; pat_idx = 0;
  endtask

  // Reference: a packet is the source's next beats up to tlast, cut at MAXB beats.
  task automatic model_pkt(input int i);
    int n = 0;
    bit l;
    pk_issued[i]++;
    do begin
      l = src_l[i][mdl_ptr[i]];
      n++;
      if (!l && n == MAXB) begin l = 1'b1; exp_lerr++; end
      exp_q.push_back({l, src_d[i][mdl_ptr[i]]});
      mdl_ptr[i]++;
    end while (!l && mdl_ptr[i] < src_d[i].size());
  endtask

  task automatic step();
    bit has, picked;
    @(negedge clk);
    if (fin_seen) begin grant = '0; served = '0; fin_seen = 0; end
    if (auto_arb && grant == '0 && ready) begin
      picked = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (!picked && mdl_ptr[i] < src_d[i].size()) begin
          picked = 1;
          grant = N'(1) << i;
          served = grant;
          model_pkt(i);
          rr = (i + 1) % N;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      has = drv_ptr[i] < src_d[i].size();
      s_tvalid[i] = has && (!gap_en || $urandom_range(0, 3) != 0);
      s_tdata[i*W +: W] = has ? src_d[i][drv_ptr[i]] : W'($urandom);
      s_tlast[i] = has ? src_l[i][drv_ptr[i]] : 1'b0;
    end
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = $urandom_range(0, 2) != 0;
      default: m_tready = rdy_pat[pat_idx % 8];
    endcase
    pat_idx++;
    #1;
    chk("s_tready_only_served", 32'(s_tready & ~served), 0);
    if (m_tvalid && !m_tready) chk("s_tready_while_stalled", 32'(s_tready), 0);
    if (hold_v && m_tvalid) chk("stall_hold", 32'({m_tlast, m_tdata}), 32'(hold_val));
    hold_v = m_tvalid && !m_tready;
    hold_val = {m_tlast, m_tdata};
    if (m_tvalid && m_tready) begin
      beats_out++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL beat_extra: got %0h expected no beat", {m_tlast, m_tdata});
      end else chk("beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
    end
    for (int i = 0; i < N; i++) if (s_tvalid[i] && s_tready[i]) drv_ptr[i]++;
    if (grant_err) gerr_cnt++;
    if (len_err) lerr_cnt++;
    if (fin != '0) begin
      chk("fin_bit", 32'(fin), 32'(served));
      chk("fin_after_all_beats", exp_q.size(), 0);
      fin_acc |= fin;
      for (int i = 0; i < N; i++) if (fin[i]) begin fin_cnt[i]++; fin_log.push_back(i); end
      fin_seen = 1;
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, 32'(ready), 1);
    chk({nm, "_fin"}, 32'(fin), 0);
    chk({nm, "_s_tready"}, 32'(s_tready), 0);
    chk({nm, "_m_tvalid"}, 32'(m_tvalid), 0);
    chk({nm, "_m_tlast"}, 32'(m_tlast), 0);
    chk({nm, "_m_tdata"}, 32'(m_tdata), 0);
    chk({nm, "_errs"}, 32'({grant_err, len_err}), 0);
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    int src;
    bit done;
    clear_env();
    auto_arb = 0; gap_en = 0; rdy_mode = v.rdy_mode; rdy_pat = v.pat;
    src = 0;
    for (int i = N - 1; i >= 0; i--) if (v.gnt[i]) src = i;
    for (int k = 0; k < v.nbeats; k++) begin
      src_d[src].push_back(W'($urandom));
      src_l[src].push_back(v.last && k == v.nbeats - 1);
    end
    grant = v.gnt;
    served = v.gnt & (~v.gnt + 1'b1);
    model_pkt(src);
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (fin != '0) done = 1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got no fin expected fin %0h", nm, v.exp_fin);
    end
    step(); step();
    chk({nm, "_fin"}, 32'(fin_acc), 32'(v.exp_fin));
    chk({nm, "_beats"}, beats_out, v.exp_beats);
    chk({nm, "_len_err"}, lerr_cnt, v.exp_lerr);
    chk({nm, "_grant_err"}, gerr_cnt, v.exp_gerr);
    chk({nm, "_ready_back"}, 32'(ready), 1);
  endtask

  vec_t vecs[7];
  vec_t v_after_rst;

  initial begin
    vecs[0] = '{4'b0100,  3, 1'b1, 0, 8'h00,       4'b0100,  3, 0, 0};
    vecs[1] = '{4'b0010,  4, 1'b1, 2, 8'b10011001, 4'b0010,  4, 0, 0};
    vecs[2] = '{4'b1000, 20, 1'b0, 0, 8'h00,       4'b1000, 16, 1, 0};
    vecs[3] = '{4'b1010,  2, 1'b1, 0, 8'h00,       4'b0010,  2, 0, 1};
    vecs[4] = '{4'b0001,  1, 1'b1, 1, 8'h00,       4'b0001,  1, 0, 0};
    vecs[5] = '{4'b0001, 16, 1'b1, 0, 8'h00,       4'b0001, 16, 0, 0};
    vecs[6] = '{4'b0100, 17, 1'b1, 1, 8'h00,       4'b0100, 16, 1, 0};
    v_after_rst = '{4'b0001, 3, 1'b1, 0, 8'h00, 4'b0001, 3, 0, 0};

    clear_env();
    auto_arb = 0; gap_en = 0; rdy_mode = 0; rr = 0; rdy_pat = '0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single source, cycle-exact latency through the mux.
    clear_env(); auto_arb = 1; rr = 0;
    for (int k = 0; k < 3; k++) begin
      src_d[2].push_back(W'(8'hA1 + k)); src_l[2].push_back(k == 2);
    end
    step(); chk("lat_ready_idle", 32'(ready), 1); chk("lat_no_sready", 32'(s_tready), 0);
    step(); chk("lat_sready", 32'(s_tready), 32'(4'b0100)); chk("lat_mvalid0", 32'(m_tvalid), 0);
    step(); chk("lat_A1", 32'({m_tvalid, m_tlast, m_tdata}), 32'({2'b10, 8'hA1}));
    step(); chk("lat_A2", 32'({m_tvalid, m_tlast, m_tdata}), 32'({2'b10, 8'hA2}));
    step(); chk("lat_A3", 32'({m_tvalid, m_tlast, m_tdata}), 32'({2'b11, 8'hA3}));
    step(); chk("lat_fin", 32'(fin), 32'(4'b0100)); chk("lat_busy", 32'(ready), 0);
    step(); chk("lat_ready_back", 32'(ready), 1); chk("lat_fin_gone", 32'(fin), 0);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: every source has a 2-beat packet; round-robin from 0.
    clear_env(); auto_arb = 1; gap_en = 0; rdy_mode = 0; rr = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        src_d[i].push_back(W'($urandom)); src_l[i].push_back(k == 1);
      end
    for (int c = 0; c < 200 && fin_log.size() < N; c++) step();
    step();
    chk("b2b_fin_count", fin_log.size(), N);
    for (int k = 0; k < N && k < fin_log.size(); k++) chk($sformatf("b2b_order%0d", k), fin_log[k], k);

    // Reset in the middle of a 5-beat packet.
    clear_env(); auto_arb = 0; gap_en = 0; rdy_mode = 0;
    for (int k = 0; k < 5; k++) begin
      src_d[2].push_back(W'($urandom)); src_l[2].push_back(k == 4);
    end
    grant = 4'b0100; served = 4'b0100; model_pkt(2);
    for (int c = 0; c < 50 && drv_ptr[2] < 2; c++) step();
    chk("midrst_two_beats_in", drv_ptr[2], 2);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    grant = '0;
    clear_env();
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(v_after_rst, "after_rst");

    // Randomized run: several packets per source, random gaps and backpressure.
    clear_env(); auto_arb = 1; gap_en = 1; rdy_mode = 1; rr = 0;
    for (int i = 0; i < N; i++) begin
      int npk;
      npk = $urandom_range(1, 4);
      for (int p = 0; p < npk; p++) begin
        int len;
        len = $urandom_range(1, 20);
        for (int k = 0; k < len; k++) begin
          src_d[i].push_back(W'($urandom)); src_l[i].push_back(k == len - 1);
        end
      end
    end
    begin
      bit finished;
      finished = 0;
      for (int c = 0; c < 20000 && !finished; c++) begin
        step();
        finished = 1;
        for (int i = 0; i < N; i++) if (mdl_ptr[i] < src_d[i].size()) finished = 0;
        if (exp_q.size() != 0 || grant != '0 || !ready) finished = 0;
      end
      if (!finished) begin
        n_cmp++; n_err++;
        $display("FAIL rand_timeout: got unfinished run expected all packets done");
      end
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rand_fin_cnt%0d", i), fin_cnt[i], pk_issued[i]);
      chk($sformatf("rand_consumed%0d", i), drv_ptr[i], src_d[i].size());
    end
    chk("rand_len_err", lerr_cnt, exp_lerr);
    chk("rand_grant_err", gerr_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
